// File: rtl/controle_pkg.sv
// ============================================================================
//  controle_pkg : shared encodings for the multicycle MIPS control unit
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package controle_pkg;

  localparam int c_state_bits = 4;
  typedef logic [c_state_bits-1:0] state_t;

  localparam logic [3:0] c_st_fetch  = 4'd0;
  localparam logic [3:0] c_st_decode = 4'd1;
  localparam logic [3:0] c_st_memadr = 4'd2;
  localparam logic [3:0] c_st_memrd  = 4'd3;
  localparam logic [3:0] c_st_memwb  = 4'd4;
  localparam logic [3:0] c_st_memwr  = 4'd5;
  localparam logic [3:0] c_st_exec   = 4'd6;
  localparam logic [3:0] c_st_aluwb  = 4'd7;
  localparam logic [3:0] c_st_branch = 4'd8;
  localparam logic [3:0] c_st_immex  = 4'd9;
  localparam logic [3:0] c_st_immwb  = 4'd10;
  localparam logic [3:0] c_st_jump   = 4'd11;
  localparam logic [3:0] c_st_err    = 4'd12;
  localparam logic [3:0] c_st_exc    = 4'd13;

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_bne  = 6'b000101;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_andi = 6'b001100;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_slti = 6'b001010;
  localparam logic [5:0] c_op_j    = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  typedef enum logic [1:0] {
    c_aluop_add   = 2'b00,
    c_aluop_sub   = 2'b01,
    c_aluop_funct = 2'b10,
    c_aluop_imm   = 2'b11
  } aluop_t;

  // Logical immediates are zero-extended; everything else is sign-extended.
  function automatic logic zero_ext_op(input logic [5:0] op);
    return (op == c_op_andi) || (op == c_op_ori);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder_mc.sv
// ============================================================================
//  alu_decoder_mc : maps {ALUop, funct, OPcode} to the 3-bit ALU control code
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module alu_decoder_mc
  import controle_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [2:0] alucontrole
);

  always_comb begin
    alucontrole = c_alu_add;
    case (aluop)
      c_aluop_add: alucontrole = c_alu_add;
      c_aluop_sub: alucontrole = c_alu_sub;
      c_aluop_funct: begin
        case (funct)
          c_fn_sub: alucontrole = c_alu_sub;
          c_fn_and: alucontrole = c_alu_and;
          c_fn_or:  alucontrole = c_alu_or;
          c_fn_slt: alucontrole = c_alu_slt;
          default:  alucontrole = c_alu_add;
        endcase
      end
      c_aluop_imm: begin
        case (opcode)
          c_op_andi: alucontrole = c_alu_and;
          c_op_ori:  alucontrole = c_alu_or;
          c_op_slti: alucontrole = c_alu_slt;
          default:   alucontrole = c_alu_add;
        endcase
      end
      default: alucontrole = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/controle_mc.sv
// ============================================================================
//  controle_mc : multicycle MIPS control FSM with memory-ready handshake and
//                bus-timeout watchdog; CONTROLE_EXC_EN adds an illegal-op trap
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module controle_mc
  import controle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OPcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               IorD,
  output logic               ALUSrcA,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUcontrole,
  output logic [STATE_W-1:0] estado,
  output logic               err,
  output logic               exc
);

  localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(MEM_TIMEOUT - 1);
  localparam logic c_wd_en = (MEM_TIMEOUT > 0);

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_wait_cnt;
  logic                w_mem_state;
  logic                w_timeout;
  aluop_t              w_aluop;
  logic                w_mem_req;
  logic                w_irwrite;
  logic                w_memwrite;
  logic                w_pcwrite;
  logic                w_branch;
  logic                w_branchne;
  logic                w_regwrite;

  assign w_mem_state = (r_state == c_st_fetch) || (r_state == c_st_memrd) ||
                       (r_state == c_st_memwr);
  // mem_ready in the limit cycle still completes the access.
  assign w_timeout   = c_wd_en && w_mem_state && !mem_ready && (r_wait_cnt == c_limit);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_fetch:  if (mem_ready) w_next = c_st_decode;
      c_st_decode: begin
        case (OPcode)
          c_op_lw, c_op_sw:                         w_next = c_st_memadr;
          c_op_r:                                   w_next = c_st_exec;
          c_op_beq, c_op_bne:                       w_next = c_st_branch;
          c_op_addi, c_op_andi, c_op_ori, c_op_slti: w_next = c_st_immex;
          c_op_j:                                   w_next = c_st_jump;
`ifdef CONTROLE_EXC_EN
          default:                                  w_next = c_st_exc;
`else
          default:                                  w_next = c_st_fetch;
`endif
        endcase
      end
      c_st_memadr: begin
        if (OPcode == c_op_lw)      w_next = c_st_memrd;
        else if (OPcode == c_op_sw) w_next = c_st_memwr;
        else                        w_next = c_st_fetch;
      end
      c_st_memrd:  if (mem_ready) w_next = c_st_memwb;
      c_st_memwb:  w_next = c_st_fetch;
      c_st_memwr:  if (mem_ready) w_next = c_st_fetch;
      c_st_exec:   w_next = c_st_aluwb;
      c_st_aluwb:  w_next = c_st_fetch;
      c_st_branch: w_next = c_st_fetch;
      c_st_immex:  w_next = c_st_immwb;
      c_st_immwb:  w_next = c_st_fetch;
      c_st_jump:   w_next = c_st_fetch;
`ifdef CONTROLE_EXC_EN
      c_st_exc:    w_next = c_st_fetch;
`endif
      c_st_err:    w_next = c_st_err;
      default:     w_next = c_st_fetch;
    endcase
    if (w_timeout) w_next = c_st_err;
  end

  // Any state change clears the counter, so each memory state starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_st_fetch;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    w_mem_req  = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_branchne = 1'b0;
    w_regwrite = 1'b0;
    ExtOp      = 1'b1;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    w_aluop    = c_aluop_add;
    case (r_state)
      c_st_fetch: begin
        w_mem_req = 1'b1;
        ALUSrcB   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      c_st_decode: ALUSrcB = 2'b11;
      c_st_memadr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      c_st_memrd: begin
        w_mem_req = 1'b1;
        IorD      = 1'b1;
      end
      c_st_memwb: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      c_st_memwr: begin
        w_mem_req  = 1'b1;
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      c_st_exec: begin
        ALUSrcA = 1'b1;
        w_aluop = c_aluop_funct;
      end
      c_st_aluwb: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      c_st_branch: begin
        ALUSrcA    = 1'b1;
        w_aluop    = c_aluop_sub;
        PCSrc      = 2'b01;
        w_branch   = (OPcode == c_op_beq);
        w_branchne = (OPcode == c_op_bne);
      end
      c_st_immex, c_st_immwb: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        w_aluop    = c_aluop_imm;
        ExtOp      = !zero_ext_op(OPcode);
        w_regwrite = (r_state == c_st_immwb);
      end
      c_st_jump: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`ifdef CONTROLE_EXC_EN
      c_st_exc: begin
        PCSrc     = 2'b11;
        w_pcwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Enables are masked while reset is held so FETCH cannot fire during reset.
  assign mem_req  = w_mem_req  & rst;
  assign IRWrite  = w_irwrite  & rst;
  assign MemWrite = w_memwrite & rst;
  assign PCWrite  = w_pcwrite  & rst;
  assign Branch   = w_branch   & rst;
  assign BranchNe = w_branchne & rst;
  assign RegWrite = w_regwrite & rst;

  assign estado = STATE_W'(r_state);
  assign err    = (r_state == c_st_err);
`ifdef CONTROLE_EXC_EN
  assign exc    = rst & (r_state == c_st_exc);
`else
  assign exc    = 1'b0;
`endif

  alu_decoder_mc u_alu_decoder (
    .aluop       (w_aluop),
    .funct       (funct),
    .opcode      (OPcode),
    .alucontrole (ALUcontrole)
  );

endmodule

`default_nettype wire

// File: tb/tb_controle_mc.sv
// ============================================================================
//  tb_controle_mc : scoreboard bench for controle_mc (MEM_TIMEOUT = 4)
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_controle_mc;
  import controle_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OPcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite;
  logic       Branch, BranchNe, RegWrite, ExtOp, err, exc;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUcontrole;
  logic [3:0] estado;

  controle_mc #(.MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .Branch(Branch), .BranchNe(BranchNe), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUcontrole(ALUcontrole), .estado(estado),
    .err(err), .exc(exc)
  );

  always #5 clk = ~clk;

  localparam int S_ST = 0, S_REQ = 1, S_M2R = 2, S_RDST = 3, S_IORD = 4, S_SRCA = 5;
  localparam int S_IRW = 6, S_MW = 7, S_PCW = 8, S_BR = 9, S_BNE = 10, S_RW = 11;
  localparam int S_EXT = 12, S_SRCB = 13, S_PCSRC = 14, S_ALU = 15, S_ERR = 16, S_EXC = 17;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [5:0] fn_tab [4];
  logic [2:0] fn_alu [4];
  logic [5:0] im_tab [4];
  logic [2:0] im_alu [4];
  logic       im_ext [4];

  task automatic chk(input string tag, input logic [7:0] obs_v, input logic [7:0] exp_v);
    n_chk++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [7:0] obs(input int s);
    case (s)
      S_ST:    return 8'(estado);
      S_REQ:   return 8'(mem_req);
      S_M2R:   return 8'(MemtoReg);
      S_RDST:  return 8'(RegDst);
      S_IORD:  return 8'(IorD);
      S_SRCA:  return 8'(ALUSrcA);
      S_IRW:   return 8'(IRWrite);
      S_MW:    return 8'(MemWrite);
      S_PCW:   return 8'(PCWrite);
      S_BR:    return 8'(Branch);
      S_BNE:   return 8'(BranchNe);
      S_RW:    return 8'(RegWrite);
      S_EXT:   return 8'(ExtOp);
      S_SRCB:  return 8'(ALUSrcB);
      S_PCSRC: return 8'(PCSrc);
      S_ALU:   return 8'(ALUcontrole);
      S_ERR:   return 8'(err);
      S_EXC:   return 8'(exc);
      default: return 8'hff;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic go(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    OPcode    = op;
    funct     = fn;
    mem_ready = rdy;
  endtask

  // Compare everything queued for this cycle mid-cycle, then step to just after the next edge.
  task automatic done;
    exp_t e;
    @(negedge clk);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input logic [5:0] op, input logic [5:0] fn, input string nm);
    go(op, fn, 1'b1);
    push_exp({nm, "_fetch"}, S_ST, 8'(c_st_fetch));
    done;
    go(op, fn, 1'b1);
    push_exp({nm, "_decode"}, S_ST, 8'(c_st_decode));
    done;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    fn_tab = '{6'b100100, 6'b100101, 6'b101010, 6'b111111};
    fn_alu = '{3'b000, 3'b001, 3'b111, 3'b010};
    im_tab = '{6'b001100, 6'b001101, 6'b001010, 6'b001000};
    im_alu = '{3'b000, 3'b001, 3'b111, 3'b010};
    im_ext = '{1'b0, 1'b0, 1'b1, 1'b1};
    @(posedge clk);
    #1;

    // Held in reset with mem_ready high: FETCH muxes, no enables.
    go(6'b100011, 6'd0, 1'b1);
    push_exp("rst_st", S_ST, 8'(c_st_fetch));
    push_exp("rst_req", S_REQ, 8'd0);
    push_exp("rst_irw", S_IRW, 8'd0);
    push_exp("rst_pcw", S_PCW, 8'd0);
    push_exp("rst_err", S_ERR, 8'd0);
    push_exp("rst_exc", S_EXC, 8'd0);
    push_exp("rst_srcb", S_SRCB, 8'd1);
    done;
    rst = 1'b1;

    // lw with ready tied high: five states.
    go(6'b100011, 6'd0, 1'b1);
    push_exp("lw_fetch", S_ST, 8'(c_st_fetch));
    push_exp("lw_fetch_req", S_REQ, 8'd1);
    push_exp("lw_fetch_irw", S_IRW, 8'd1);
    push_exp("lw_fetch_pcw", S_PCW, 8'd1);
    push_exp("lw_fetch_srcb", S_SRCB, 8'd1);
    push_exp("lw_fetch_alu", S_ALU, 8'b010);
    push_exp("lw_fetch_pcsrc", S_PCSRC, 8'd0);
    done;
    go(6'b100011, 6'd0, 1'b1);
    push_exp("lw_decode", S_ST, 8'(c_st_decode));
    push_exp("lw_decode_srcb", S_SRCB, 8'd3);
    push_exp("lw_decode_irw", S_IRW, 8'd0);
    done;
    go(6'b100011, 6'd0, 1'b1);
    push_exp("lw_memadr", S_ST, 8'(c_st_memadr));
    push_exp("lw_memadr_srca", S_SRCA, 8'd1);
    push_exp("lw_memadr_srcb", S_SRCB, 8'd2);
    done;
    go(6'b100011, 6'd0, 1'b1);
    push_exp("lw_memrd", S_ST, 8'(c_st_memrd));
    push_exp("lw_memrd_req", S_REQ, 8'd1);
    push_exp("lw_memrd_iord", S_IORD, 8'd1);
    done;
    go(6'b100011, 6'd0, 1'b1);
    push_exp("lw_memwb", S_ST, 8'(c_st_memwb));
    push_exp("lw_memwb_rw", S_RW, 8'd1);
    push_exp("lw_memwb_m2r", S_M2R, 8'd1);
    done;

    // Slow fetch: 3 wait cycles, ready at the timeout-limit cycle still wins.
    for (int i = 0; i < 3; i++) begin
      go(6'b000000, 6'b100010, 1'b0);
      push_exp("slow_fetch_st", S_ST, 8'(c_st_fetch));
      push_exp("slow_fetch_irw", S_IRW, 8'd0);
      push_exp("slow_fetch_pcw", S_PCW, 8'd0);
      done;
    end
    go(6'b000000, 6'b100010, 1'b1);
    push_exp("slow_ready_irw", S_IRW, 8'd1);
    push_exp("slow_ready_pcw", S_PCW, 8'd1);
    done;
    go(6'b000000, 6'b100010, 1'b0);
    push_exp("sub_decode", S_ST, 8'(c_st_decode));
    done;
    go(6'b000000, 6'b100010, 1'b0);
    push_exp("sub_exec", S_ST, 8'(c_st_exec));
    push_exp("sub_exec_alu", S_ALU, 8'b110);
    push_exp("sub_exec_srca", S_SRCA, 8'd1);
    push_exp("sub_exec_srcb", S_SRCB, 8'd0);
    done;
    go(6'b000000, 6'b100010, 1'b0);
    push_exp("sub_aluwb", S_ST, 8'(c_st_aluwb));
    push_exp("sub_aluwb_rdst", S_RDST, 8'd1);
    push_exp("sub_aluwb_rw", S_RW, 8'd1);
    done;

    // R-type functs, including an unknown one decoding to add.
    for (int i = 0; i < 4; i++) begin
      fd(6'b000000, fn_tab[i], "rtype");
      go(6'b000000, fn_tab[i], 1'b1);
      push_exp("rtype_exec_alu", S_ALU, 8'(fn_alu[i]));
      done;
      go(6'b000000, fn_tab[i], 1'b1);
      push_exp("rtype_aluwb", S_ST, 8'(c_st_aluwb));
      done;
    end

    // I-type ALU ops: andi, ori, slti, addi.
    for (int i = 0; i < 4; i++) begin
      fd(im_tab[i], 6'd0, "imm");
      go(im_tab[i], 6'd0, 1'b1);
      push_exp("immex_st", S_ST, 8'(c_st_immex));
      push_exp("immex_alu", S_ALU, 8'(im_alu[i]));
      push_exp("immex_ext", S_EXT, 8'(im_ext[i]));
      push_exp("immex_srcb", S_SRCB, 8'd2);
      push_exp("immex_rw", S_RW, 8'd0);
      done;
      go(im_tab[i], 6'd0, 1'b1);
      push_exp("immwb_st", S_ST, 8'(c_st_immwb));
      push_exp("immwb_rw", S_RW, 8'd1);
      push_exp("immwb_rdst", S_RDST, 8'd0);
      push_exp("immwb_ext", S_EXT, 8'(im_ext[i]));
      push_exp("immwb_alu", S_ALU, 8'(im_alu[i]));
      done;
    end

    fd(6'b000101, 6'd0, "bne");
    go(6'b000101, 6'd0, 1'b1);
    push_exp("bne_st", S_ST, 8'(c_st_branch));
    push_exp("bne_bne", S_BNE, 8'd1);
    push_exp("bne_br", S_BR, 8'd0);
    push_exp("bne_pcsrc", S_PCSRC, 8'd1);
    push_exp("bne_alu", S_ALU, 8'b110);
    done;
    fd(6'b000100, 6'd0, "beq");
    go(6'b000100, 6'd0, 1'b1);
    push_exp("beq_br", S_BR, 8'd1);
    push_exp("beq_bne", S_BNE, 8'd0);
    done;
    fd(6'b000010, 6'd0, "j");
    go(6'b000010, 6'd0, 1'b1);
    push_exp("j_st", S_ST, 8'(c_st_jump));
    push_exp("j_pcw", S_PCW, 8'd1);
    push_exp("j_pcsrc", S_PCSRC, 8'd2);
    done;

    // Illegal opcode.
    fd(6'b111111, 6'd0, "ill");
`ifdef CONTROLE_EXC_EN
    go(6'b111111, 6'd0, 1'b0);
    push_exp("ill_exc_st", S_ST, 8'(c_st_exc));
    push_exp("ill_exc", S_EXC, 8'd1);
    push_exp("ill_exc_pcsrc", S_PCSRC, 8'd3);
    push_exp("ill_exc_pcw", S_PCW, 8'd1);
    done;
`endif
    go(6'b111111, 6'd0, 1'b0);
    push_exp("ill_next_st", S_ST, 8'(c_st_fetch));
    push_exp("ill_next_exc", S_EXC, 8'd0);
    done;

    // Reset in the middle of a pending store.
    fd(6'b101011, 6'd0, "swr");
    go(6'b101011, 6'd0, 1'b1);
    done;
    go(6'b101011, 6'd0, 1'b0);
    push_exp("swr_memwr", S_ST, 8'(c_st_memwr));
    push_exp("swr_mw", S_MW, 8'd1);
    done;
    rst = 1'b0;
    go(6'b101011, 6'd0, 1'b1);
    push_exp("midrst_st", S_ST, 8'(c_st_fetch));
    push_exp("midrst_mw", S_MW, 8'd0);
    push_exp("midrst_req", S_REQ, 8'd0);
    push_exp("midrst_irw", S_IRW, 8'd0);
    done;
    rst = 1'b1;

    // Store with ready never arriving: 4 wait cycles, then sticky ERR.
    fd(6'b101011, 6'd0, "swt");
    go(6'b101011, 6'd0, 1'b0);
    done;
    for (int i = 0; i < 4; i++) begin
      go(6'b101011, 6'd0, 1'b0);
      push_exp("swt_memwr", S_ST, 8'(c_st_memwr));
      push_exp("swt_mw", S_MW, 8'd1);
      push_exp("swt_err", S_ERR, 8'd0);
      done;
    end
    go(6'b101011, 6'd0, 1'b0);
    push_exp("swt_err_st", S_ST, 8'(c_st_err));
    push_exp("swt_err_flag", S_ERR, 8'd1);
    push_exp("swt_err_mw", S_MW, 8'd0);
    push_exp("swt_err_req", S_REQ, 8'd0);
    done;
    go(6'b101011, 6'd0, 1'b1);
    push_exp("err_sticky_st", S_ST, 8'(c_st_err));
    push_exp("err_sticky", S_ERR, 8'd1);
    done;
    rst = 1'b0;
    go(6'b101011, 6'd0, 1'b1);
    push_exp("err_clr", S_ERR, 8'd0);
    push_exp("err_clr_st", S_ST, 8'(c_st_fetch));
    done;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
